// File: rtl/game_pkg.sv
// game_pkg: shared state encoding for the game sequencer.
// The 4-bit encodings are visible on state_dbg, so keep them stable.
package game_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESTART    = 4'd0,
    ST_IDLE       = 4'd1,
    ST_BLACK      = 4'd2,
    ST_INIT_UPD   = 4'd3,
    ST_INIT_PLOT  = 4'd4,
    ST_BANNER     = 4'd5,
    ST_WAIT_COLOR = 4'd6,
    ST_WAIT_REL   = 4'd7,
    ST_UPDATE     = 4'd8,
    ST_PLOT       = 4'd9,
    ST_STEPS      = 4'd10,
    ST_CHECK      = 4'd11,
    ST_AI         = 4'd12,
    ST_END        = 4'd13
  } state_t;

endpackage

// File: rtl/color_select.sv
// color_select: picks the lowest-index pressed button and looks up its
// colour code in the packed COLOR_MAP table (index 0 in the LSBs).
module color_select #(
  parameter int NUM_COLORS = 4,
  parameter int COLOR_W    = 3,
  parameter logic [NUM_COLORS*COLOR_W-1:0] COLOR_MAP = {3'b111, 3'b011, 3'b101, 3'b001}
) (
  input  logic [NUM_COLORS-1:0] btn,
  output logic                  valid,
  output logic [COLOR_W-1:0]    code
);

  // Scan from the top down so the lowest asserted index wins.
  always_comb begin
    valid = 1'b0;
    code  = COLOR_MAP[COLOR_W-1:0];
    for (int i = NUM_COLORS - 1; i >= 0; i--) begin
      if (btn[i]) begin
        valid = 1'b1;
        code  = COLOR_MAP[i*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level control FSM for the colour game.
// Sequences screen init, banner, step display, win check, optional AI
// turn and player colour entry; counts moves and forces END at MAX_MOVES.
// Optional feature: define GAME_SEQ_AI_EN to enable the AI turn state,
// do_ai and the ai_color path; otherwise CHECK returns straight to
// WAIT_COLOR and the AI inputs are ignored.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_COLORS = 4,
  parameter int COLOR_W    = 3,
  parameter logic [NUM_COLORS*COLOR_W-1:0] COLOR_MAP = {3'b111, 3'b011, 3'b101, 3'b001},
  parameter int MAX_MOVES  = 25
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           ai_en,
  input  logic [NUM_COLORS-1:0]          btn,
  input  logic                           done_reset,
  input  logic                           done_black,
  input  logic                           done_init_upd,
  input  logic                           done_init_plot,
  input  logic                           done_update,
  input  logic                           done_draw,
  input  logic                           done_banner,
  input  logic                           done_steps,
  input  logic                           done_check,
  input  logic                           game_over,
  input  logic                           ai_done,
  input  logic                           turn_ai,
  input  logic [COLOR_W-1:0]             ai_color,
  output logic                           sig_reset,
  output logic                           black,
  output logic                           init_update,
  output logic                           init_plot,
  output logic                           update,
  output logic                           plot,
  output logic                           plot_banner,
  output logic                           plot_steps,
  output logic                           check,
  output logic                           do_ai,
  output logic                           game_end,
  output logic [COLOR_W-1:0]             color_out,
  output logic [$clog2(MAX_MOVES+1)-1:0] move_count,
  output logic [3:0]                     state_dbg
);

  localparam int MC_W = $clog2(MAX_MOVES + 1);
  localparam logic [MC_W-1:0] MOVE_LIMIT = MC_W'(MAX_MOVES);

  state_t             state_reg, state_next;
  logic               restart_pend_reg, restart_pend_next;
  logic [MC_W-1:0]    move_count_reg, move_count_next;
  logic [COLOR_W-1:0] color_out_reg, color_out_next;
  logic               sel_valid;
  logic [COLOR_W-1:0] sel_code;

  color_select #(
    .NUM_COLORS(NUM_COLORS),
    .COLOR_W   (COLOR_W),
    .COLOR_MAP (COLOR_MAP)
  ) u_color_select (
    .btn  (btn),
    .valid(sel_valid),
    .code (sel_code)
  );

`ifndef GAME_SEQ_AI_EN
  // AI inputs have no function in this build.
  logic unused_ai_inputs;
  assign unused_ai_inputs = ^{ai_en, turn_ai, ai_color, ai_done};
`endif

  // State and datapath registers; reset lands in BANNER with a restart pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_BANNER;
      restart_pend_reg <= 1'b1;
      move_count_reg   <= '0;
      color_out_reg    <= COLOR_MAP[COLOR_W-1:0];
    end else begin
      state_reg        <= state_next;
      restart_pend_reg <= restart_pend_next;
      move_count_reg   <= move_count_next;
      color_out_reg    <= color_out_next;
    end
  end

  // Next-state logic; each done input is only looked at in its own state.
  always_comb begin
    state_next        = state_reg;
    restart_pend_next = restart_pend_reg;
    move_count_next   = move_count_reg;
    color_out_next    = color_out_reg;
    case (state_reg)
      ST_RESTART: begin
        move_count_next = '0;
        if (done_reset) state_next = ST_IDLE;
      end
      ST_IDLE:      if (start)          state_next = ST_BLACK;
      ST_BLACK:     if (done_black)     state_next = ST_INIT_UPD;
      ST_INIT_UPD:  if (done_init_upd)  state_next = ST_INIT_PLOT;
      ST_INIT_PLOT: if (done_init_plot) state_next = ST_BANNER;
      ST_BANNER: begin
        if (done_banner) begin
          restart_pend_next = 1'b0;
          if (restart_pend_reg)
            state_next = ST_RESTART;
          else if (game_over || (move_count_reg >= MOVE_LIMIT))
            state_next = ST_END;
          else
            state_next = ST_STEPS;
        end
      end
      ST_WAIT_COLOR: begin
`ifdef GAME_SEQ_AI_EN
        if (ai_en && turn_ai) begin
          color_out_next = ai_color;
          state_next     = ST_UPDATE;
        end else if (sel_valid) begin
          color_out_next = sel_code;
          state_next     = ST_WAIT_REL;
        end
`else
        if (sel_valid) begin
          color_out_next = sel_code;
          state_next     = ST_WAIT_REL;
        end
`endif
      end
      ST_WAIT_REL:  if (btn == '0) state_next = ST_UPDATE;
      ST_UPDATE: begin
        if (done_update) begin
          state_next = ST_PLOT;
          if (move_count_reg < MOVE_LIMIT) move_count_next = move_count_reg + MC_W'(1);
        end
      end
      ST_PLOT:      if (done_draw)  state_next = ST_BANNER;
      ST_STEPS:     if (done_steps) state_next = ST_CHECK;
      ST_CHECK: begin
        if (done_check) begin
`ifdef GAME_SEQ_AI_EN
          state_next = game_over ? ST_BANNER : ST_AI;
`else
          state_next = game_over ? ST_BANNER : ST_WAIT_COLOR;
`endif
        end
      end
      ST_AI: begin
`ifdef GAME_SEQ_AI_EN
        if (ai_done) state_next = ST_WAIT_COLOR;
`else
        state_next = ST_WAIT_COLOR;
`endif
      end
      ST_END:  state_next = ST_END;
      default: state_next = ST_RESTART;
    endcase
  end

  // Output decode: pure function of the current state (and the restart flag in BANNER).
  always_comb begin
    sig_reset   = 1'b0;
    black       = 1'b0;
    init_update = 1'b0;
    init_plot   = 1'b0;
    update      = 1'b0;
    plot        = 1'b0;
    plot_banner = 1'b0;
    plot_steps  = 1'b0;
    check       = 1'b0;
    do_ai       = 1'b0;
    game_end    = 1'b0;
    case (state_reg)
      ST_RESTART:   sig_reset = 1'b1;
      ST_BLACK:     begin black = 1'b1; plot = 1'b1; end
      ST_INIT_UPD:  init_update = 1'b1;
      ST_INIT_PLOT: begin init_plot = 1'b1; plot = 1'b1; end
      ST_UPDATE:    update = 1'b1;
      ST_PLOT:      plot = 1'b1;
      ST_BANNER: begin
        plot_banner = 1'b1;
        plot        = 1'b1;
        game_end    = restart_pend_reg;
      end
      ST_STEPS:     plot_steps = 1'b1;
      ST_CHECK:     check = 1'b1;
`ifdef GAME_SEQ_AI_EN
      ST_AI:        do_ai = 1'b1;
`endif
      ST_END:       game_end = 1'b1;
      default: ;
    endcase
  end

  assign color_out  = color_out_reg;
  assign move_count = move_count_reg;
  assign state_dbg  = state_reg;

endmodule
